reg_file_read: RTL and testbench

- Register-file storage and registered read port for the 8086-style general registers.
- Owns the eight byte registers AL, CL, DL, BL, AH, CH, DH, BH and the four word registers SP, BP, SI, DI.
- Written through the 12-bit one-hot-per-slot write-enable vector produced by the write decoder; WDATA accompanies it.
- Serves the read side of the same 4-bit register select encoding, with a request/valid/stall handshake, same-cycle write forwarding, and optional sign extension of byte reads.

---
 rtl/reg_file_read_if.sv | 33 +++
 rtl/reg_file_read.sv | 96 +++++++++
 tb/tb_reg_file_read.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_read_if.sv
// rtl/reg_file_read_if.sv - write/read bus bundle for the general register file
//
// Signals:
//   we[11:0]     write enables, one per slot (11 AL .. 4 BH, 3 SP, 2 BP, 1 SI, 0 DI)
//   wdata[15:0]  write data
//   rd_req       read request
//   rd_sel[3:0]  register select (0-7 bytes, 8-11 AX..BX, 12-15 SP..DI)
//   rd_sext      sign-extend byte reads
//   rd_stall     consumer not ready to take rd_data
//   rd_ready     request can be accepted this cycle
//   rd_valid     rd_data holds a completed read
//   rd_data      read result
interface reg_file_read_if;
    logic [11:0] we;
    logic [15:0] wdata;
    logic        rd_req;
    logic [3:0]  rd_sel;
    logic        rd_sext;
    logic        rd_stall;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;

    modport master (
        output we, wdata, rd_req, rd_sel, rd_sext, rd_stall,
        input  rd_ready, rd_valid, rd_data
    );

    modport slave (
        input  we, wdata, rd_req, rd_sel, rd_sext, rd_stall,
        output rd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/reg_file_read.sv
// rtl/reg_file_read.sv - 8086-style general register file with registered read port
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    reg_file_read_if.slave: write enables/data in, read request/select/
//          sext/stall in, rd_ready/rd_valid/rd_data out
//
// Slot arrays are ordered so that each enable bit indexes its slot directly:
// lo[3..0] = AL,CL,DL,BL (we[11:8]), hi[3..0] = AH,CH,DH,BH (we[7:4]),
// wd[3..0] = SP,BP,SI,DI (we[3:0]). A select's low two bits therefore map to
// slot index ~rd_sel[1:0].
module reg_file_read #(
    parameter logic [15:0] SP_RESET = 16'h0000
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_file_read_if.slave bus
);

    logic [3:0][7:0]  lo_q, lo_n;
    logic [3:0][7:0]  hi_q, hi_n;
    logic [3:0][15:0] wd_q, wd_n;

    logic        rd_valid_q;
    logic [15:0] rd_data_q;
    logic [1:0]  idx;
    logic [7:0]  rd_byte;
    logic [15:0] rd_result;
    logic        hold;
    logic        accept;

    // Next-state slot values; the read path also uses these so a write at the
    // accepting edge is forwarded into the result byte by byte.
    always_comb begin
        lo_n = lo_q;
        hi_n = hi_q;
        wd_n = wd_q;
        for (int i = 0; i < 4; i++) begin
            if (bus.we[8+i]) begin
                lo_n[i] = bus.wdata[7:0];
            end
            // A high byte takes the upper data byte only as part of a pair write;
            // written alone it takes the low data byte.
            if (bus.we[4+i]) begin
                hi_n[i] = bus.we[8+i] ? bus.wdata[15:8] : bus.wdata[7:0];
            end
            if (bus.we[i]) begin
                wd_n[i] = bus.wdata;
            end
        end
    end

    assign idx = ~bus.rd_sel[1:0];

    always_comb begin
        rd_byte   = bus.rd_sel[2] ? hi_n[idx] : lo_n[idx];
        rd_result = 16'h0000;
        case (bus.rd_sel[3:2])
            2'b00, 2'b01: rd_result = bus.rd_sext ? {{8{rd_byte[7]}}, rd_byte}
                                                  : {8'h00, rd_byte};
            2'b10:        rd_result = {hi_n[idx], lo_n[idx]};
            default:      rd_result = wd_n[idx];
        endcase
    end

    assign hold   = rd_valid_q & bus.rd_stall;
    assign accept = bus.rd_req & ~hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q       <= '0;
            hi_q       <= '0;
            wd_q       <= {SP_RESET, 16'h0000, 16'h0000, 16'h0000};
            rd_valid_q <= 1'b0;
            rd_data_q  <= 16'h0000;
        end else begin
            lo_q <= lo_n;
            hi_q <= hi_n;
            wd_q <= wd_n;
            // While held the output is a snapshot: writes to the source slot
            // do not reach it.
            if (!hold) begin
                rd_valid_q <= accept;
                if (accept) begin
                    rd_data_q <= rd_result;
                end
            end
        end
    end

    assign bus.rd_ready = ~hold;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_reg_file_read.sv
// tb/tb_reg_file_read.sv - scoreboard bench for reg_file_read
module tb_reg_file_read;

    localparam logic [15:0] SP_RST = 16'hFFFE;

    logic clk;
    logic rst_n;

    reg_file_read_if bus ();

    reg_file_read #(.SP_RESET(SP_RST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: m_b[0..7] = AL,CL,DL,BL,AH,CH,DH,BH; m_w[0..3] = SP,BP,SI,DI
    logic [7:0]  m_b [8];
    logic [15:0] m_w [4];
    logic        exp_valid;
    logic [15:0] held;
    logic [15:0] sb [$];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_b[k] = 8'h00;
        m_w[0] = SP_RST;
        m_w[1] = 16'h0000;
        m_w[2] = 16'h0000;
        m_w[3] = 16'h0000;
        exp_valid = 1'b0;
        held = 16'h0000;
        sb.delete();
    endtask

    task automatic model_write(input logic [11:0] we, input logic [15:0] wd);
        for (int k = 0; k < 4; k++) begin
            if (we[7-k]) m_b[4+k] = we[11-k] ? wd[15:8] : wd[7:0];
            if (we[11-k]) m_b[k] = wd[7:0];
            if (we[3-k]) m_w[k] = wd;
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] sel, input logic sext);
        logic [7:0] b;
        if (sel < 4'd8) begin
            b = m_b[sel];
            return sext ? {{8{b[7]}}, b} : {8'h00, b};
        end else if (sel < 4'd12) begin
            return {m_b[sel - 4'd4], m_b[sel - 4'd8]};
        end
        return m_w[sel - 4'd12];
    endfunction

    task automatic step(input logic [11:0] we_i, input logic [15:0] wd_i, input logic req_i,
                        input logic [3:0] sel_i, input logic sext_i, input logic stall_i);
        logic acc;
        @(negedge clk);
        bus.we       = we_i;
        bus.wdata    = wd_i;
        bus.rd_req   = req_i;
        bus.rd_sel   = sel_i;
        bus.rd_sext  = sext_i;
        bus.rd_stall = stall_i;
        #1;
        chk("rd_ready", 16'(bus.rd_ready), 16'(!(exp_valid && stall_i)));
        acc = req_i && !(exp_valid && stall_i);
        model_write(we_i, wd_i);
        if (acc) sb.push_back(model_read(sel_i, sext_i));
        @(posedge clk);
        #1;
        if (!(exp_valid && stall_i)) exp_valid = acc;
        chk("rd_valid", 16'(bus.rd_valid), 16'(exp_valid));
        if (acc) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty: got no entry expected one");
            end else begin
                held = sb.pop_front();
                chk("rd_data", bus.rd_data, held);
            end
        end else begin
            chk("rd_hold", bus.rd_data, held);
        end
    endtask

    task automatic rd(input logic [3:0] sel, input logic sext);
        step(12'h000, 16'h0000, 1'b1, sel, sext, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.we       = '0;
        bus.wdata    = '0;
        bus.rd_req   = 1'b0;
        bus.rd_sel   = '0;
        bus.rd_sext  = 1'b0;
        bus.rd_stall = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 16'(bus.rd_valid), 16'h0000);
        chk("rst_data", bus.rd_data, 16'h0000);
        chk("rst_ready", 16'(bus.rd_ready), 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset contents
        rd(4'd8, 1'b0);
        chk("t1_ax", bus.rd_data, 16'h0000);
        rd(4'd12, 1'b0);
        chk("t1_sp", bus.rd_data, SP_RST);

        // Pair write AH/AL, then byte/word views
        step(12'b100010000000, 16'h12F4, 1'b0, 4'd0, 1'b0, 1'b0);
        rd(4'd0, 1'b0);
        chk("t2_al_z", bus.rd_data, 16'h00F4);
        rd(4'd0, 1'b1);
        chk("t2_al_s", bus.rd_data, 16'hFFF4);
        rd(4'd4, 1'b0);
        chk("t2_ah", bus.rd_data, 16'h0012);
        rd(4'd8, 1'b0);
        chk("t2_ax", bus.rd_data, 16'h12F4);

        // AH alone takes the low data byte
        step(12'b000010000000, 16'h00AB, 1'b0, 4'd0, 1'b0, 1'b0);
        rd(4'd8, 1'b0);
        chk("t3_ax", bus.rd_data, 16'hABF4);

        // Same-edge write forwarding into SI
        step(12'b000000000010, 16'hBEEF, 1'b1, 4'd14, 1'b0, 1'b0);
        chk("t4_si_fwd", bus.rd_data, 16'hBEEF);

        // Per-byte forwarding: AL only written, AX read
        step(12'b100000000000, 16'h5566, 1'b1, 4'd8, 1'b0, 1'b0);
        chk("t4_ax_fwd", bus.rd_data, 16'hAB66);
        step(12'b000000000010, 16'hBEEF, 1'b1, 4'd14, 1'b0, 1'b0);

        // Stall holds a snapshot while SI is rewritten
        step(12'b000000000010, 16'h1111, 1'b1, 4'd14, 1'b0, 1'b1);
        chk("t5_hold0", bus.rd_data, 16'hBEEF);
        step(12'b000000000000, 16'h0000, 1'b1, 4'd14, 1'b0, 1'b1);
        step(12'b000000000000, 16'h0000, 1'b1, 4'd14, 1'b0, 1'b1);
        chk("t5_hold2", bus.rd_data, 16'hBEEF);
        rd(4'd14, 1'b0);
        chk("t5_si_new", bus.rd_data, 16'h1111);

        // Stall with no valid result has no effect
        step(12'h000, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
        step(12'h000, 16'h0000, 1'b1, 4'd12, 1'b0, 1'b1);
        chk("t5_idle_stall", bus.rd_data, SP_RST);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            step(12'($urandom), 16'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
                 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset mid-cycle with a valid result
        step(12'h000, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
        step(12'b111111111111, 16'h8421, 1'b1, 4'd9, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 16'(bus.rd_valid), 16'h0000);
        chk("t6_data", bus.rd_data, 16'h0000);
        chk("t6_ready", 16'(bus.rd_ready), 16'h0001);
        bus.rd_req = 1'b0;
        bus.we     = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 16; s++) begin
            rd(4'(s), 1'b1);
        end
        chk("t6_sp", bus.rd_data, 16'h0000);
        rd(4'd12, 1'b0);
        chk("t6_sp2", bus.rd_data, SP_RST);

        step(12'h000, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("sb_drained", 16'(sb.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
